// File: rtl/async_handshake_sink.sv
// Receive side of a toggle-handshake CDC. Each request toggle produces one captured word
// on a valid/ready port, and an acknowledge toggle is returned once that word is consumed.
module async_handshake_sink #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_toggle,
  input  logic [WIDTH-1:0] io_data,
  output logic             io_ack_toggle,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic             io_protocol_error
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [DEPTH-1:0] sync_reg;
  logic             sync_out;
  logic             sync_prev_reg;
  logic             req_seen_reg;
  logic             ack_reg;
  logic [0:0]       state_reg;
  logic [WIDTH-1:0] bits_reg;
  logic             error_reg;
  logic             pending;
  logic             fire;

  // Plain flop chain with no logic between stages, so the tools can treat it as a synchronizer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[DEPTH-2:0], io_req_toggle};
    end
  end

  assign sync_out     = sync_reg[DEPTH-1];
  assign pending      = sync_out ^ req_seen_reg;
  assign io_deq_valid = (state_reg == HOLD);
  assign fire         = io_deq_valid && io_deq_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      req_seen_reg  <= 1'b0;
      ack_reg       <= 1'b0;
      bits_reg      <= '0;
      error_reg     <= 1'b0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_prev_reg <= sync_out;
      // A second toggle arriving while a word is still held means the source skipped the ack.
      if (state_reg == HOLD && sync_out != sync_prev_reg) begin
        error_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pending) begin
            bits_reg  <= io_data;
            state_reg <= HOLD;
          end
        end
        default: begin
          if (fire) begin
            ack_reg      <= ~ack_reg;
            req_seen_reg <= ~req_seen_reg;
            state_reg    <= IDLE;
          end
        end
      endcase
    end
  end

  assign io_ack_toggle     = ack_reg;
  assign io_deq_bits       = bits_reg;
  assign io_protocol_error = error_reg;

endmodule

// File: tb/tb_async_handshake_sink.sv
// Scoreboard bench for async_handshake_sink: words are queued as they are requested and
// compared as each valid/ready handshake is observed.
module tb_async_handshake_sink;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_req_toggle = 1'b0;
  logic [WIDTH-1:0] io_data = '0;
  logic             io_ack_toggle;
  logic             io_deq_valid;
  logic             io_deq_ready = 1'b0;
  logic [WIDTH-1:0] io_deq_bits;
  logic             io_protocol_error;

  int vectors = 0;
  int miscompares = 0;
  int handshakes = 0;
  logic [WIDTH-1:0] sb[$];

  async_handshake_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_req_toggle     (io_req_toggle),
    .io_data           (io_data),
    .io_ack_toggle     (io_ack_toggle),
    .io_deq_valid      (io_deq_valid),
    .io_deq_ready      (io_deq_ready),
    .io_deq_bits       (io_deq_bits),
    .io_protocol_error (io_protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, actual);
    end
  endtask

  // Inputs change and most checks happen 1 time unit after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (io_deq_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("valid_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_ack(input logic old_ack, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (io_ack_toggle !== old_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Handshake monitor: a valid&&ready seen at the falling edge completes on the next rising edge.
  always @(negedge clock) begin
    if (!reset && io_deq_valid && io_deq_ready) begin
      handshakes++;
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        check("deq_bits", io_deq_bits, sb.pop_front());
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] held;

    // Reset state
    step();
    step();
    check("rst_valid", {31'd0, io_deq_valid}, 32'd0);
    check("rst_bits", io_deq_bits, 32'd0);
    check("rst_ack", {31'd0, io_ack_toggle}, 32'd0);
    check("rst_err", {31'd0, io_protocol_error}, 32'd0);
    reset = 1'b0;
    step();

    // Basic transfer: toggle at cycle 0, valid at DEPTH+1, ack at the cycle after the handshake
    io_deq_ready  = 1'b1;
    io_data       = 32'hDEADBEEF;
    io_req_toggle = 1'b1;
    sb.push_back(32'hDEADBEEF);
    for (int c = 1; c <= DEPTH; c++) begin
      step();
      check("basic_valid_early", {31'd0, io_deq_valid}, 32'd0);
    end
    step();
    check("basic_valid", {31'd0, io_deq_valid}, 32'd1);
    check("basic_bits", io_deq_bits, 32'hDEADBEEF);
    check("basic_ack_before", {31'd0, io_ack_toggle}, 32'd0);
    step();
    check("basic_ack", {31'd0, io_ack_toggle}, 32'd1);
    check("basic_valid_drop", {31'd0, io_deq_valid}, 32'd0);

    // Backpressure with data changing under the held word
    io_deq_ready  = 1'b0;
    io_data       = 32'hA5A50001;
    io_req_toggle = 1'b0;
    sb.push_back(32'hA5A50001);
    wait_valid(20);
    held = io_deq_bits;
    check("bp_bits", held, 32'hA5A50001);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) io_data = 32'hFFFF0000;
      step();
      check("bp_valid", {31'd0, io_deq_valid}, 32'd1);
      check("bp_bits_stable", io_deq_bits, 32'hA5A50001);
      check("bp_ack", {31'd0, io_ack_toggle}, 32'd1);
    end
    io_deq_ready = 1'b1;
    step();
    check("bp_ack_flip", {31'd0, io_ack_toggle}, 32'd0);
    for (int c = 0; c < 8; c++) step();
    check("bp_ack_once", {31'd0, io_ack_toggle}, 32'd0);
    check("bp_valid_idle", {31'd0, io_deq_valid}, 32'd0);

    // Sequence of 8 words, source waits for each ack edge
    for (int i = 1; i <= 8; i++) begin
      logic old_ack;
      old_ack       = io_ack_toggle;
      io_data       = WIDTH'(i);
      io_req_toggle = ~io_req_toggle;
      sb.push_back(WIDTH'(i));
      wait_ack(old_ack, 40);
    end
    check("seq_ack_final", {31'd0, io_ack_toggle}, 32'd0);
    check("seq_err", {31'd0, io_protocol_error}, 32'd0);
    check("seq_handshakes", handshakes, 32'd10);

    // Protocol violation: two extra toggles while the word is held
    io_deq_ready  = 1'b0;
    io_data       = 32'h12345678;
    io_req_toggle = ~io_req_toggle;
    sb.push_back(32'h12345678);
    wait_valid(20);
    check("pv_err_before", {31'd0, io_protocol_error}, 32'd0);
    io_req_toggle = ~io_req_toggle;
    for (int c = 0; c < 6; c++) step();
    check("pv_err_set", {31'd0, io_protocol_error}, 32'd1);
    io_req_toggle = ~io_req_toggle;
    for (int c = 0; c < 6; c++) step();
    check("pv_err_sticky", {31'd0, io_protocol_error}, 32'd1);
    check("pv_valid_held", {31'd0, io_deq_valid}, 32'd1);
    io_deq_ready = 1'b1;
    step();
    check("pv_ack", {31'd0, io_ack_toggle}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      check("pv_no_extra_valid", {31'd0, io_deq_valid}, 32'd0);
    end
    check("pv_err_after", {31'd0, io_protocol_error}, 32'd1);

    // Reset mid-HOLD clears everything asynchronously; the word is discarded
    io_deq_ready  = 1'b0;
    io_data       = 32'hCAFEF00D;
    io_req_toggle = ~io_req_toggle;
    wait_valid(20);
    check("rm_bits_before", io_deq_bits, 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    check("rm_valid", {31'd0, io_deq_valid}, 32'd0);
    check("rm_bits", io_deq_bits, 32'd0);
    check("rm_ack", {31'd0, io_ack_toggle}, 32'd0);
    check("rm_err", {31'd0, io_protocol_error}, 32'd0);
    io_req_toggle = 1'b0;
    io_deq_ready  = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("rm_quiet", {31'd0, io_deq_valid}, 32'd0);
    end

    // Reset released with the request toggle already high counts as one request
    reset         = 1'b1;
    io_req_toggle = 1'b1;
    io_data       = 32'h0BADCAFE;
    sb.push_back(32'h0BADCAFE);
    step();
    reset = 1'b0;
    wait_valid(20);
    step();
    check("rh_ack", {31'd0, io_ack_toggle}, 32'd1);
    for (int c = 0; c < 10; c++) step();
    check("rh_valid_idle", {31'd0, io_deq_valid}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    check("total_handshakes", handshakes, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
